// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with run-time parity selection.
//
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then
// STOP_BITS stop bits. Each completed frame is offered on a valid/ready
// output together with its parity and framing flags. A frame that completes
// while the previous word is still unaccepted is dropped and flagged as
// overrun.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate; CLKS_PER_BIT = CLK_FREQ / BAUD (truncated, >= 2)
//   DATA_BITS  data bits per frame, 5..9
//   STOP_BITS  stop bits checked, 1 or 2
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_rx           asynchronous serial line, idle high
//   i_parity_mode  00 none, 01 even, 10 odd, 11 none (latched per frame)
//   o_data         received word
//   o_valid        o_data and flags valid; held until accepted
//   i_ready        consumer accepts on o_valid & i_ready
//   o_parity_err   parity mismatch for the presented word
//   o_frame_err    a stop bit was sampled low
//   o_overrun      at least one frame was dropped while o_valid was held
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit is the 2-of-3 majority of the
//                        synchronised samples at mid-1, mid and mid+1; the
//                        decision (and all outputs) move one cycle later.

module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic [1:0]           i_parity_mode,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  // The counter starts one cycle after the synchronised edge is seen, and
  // the synchronised value lags the line by two cycles; a start-bit compare
  // value of HALF_BIT-1 therefore lands on line time HALF_BIT after the edge.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_SAMPLE = HALF_BIT;
`else
  localparam int START_SAMPLE = HALF_BIT - 1;
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_SAMPLE);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           mode_q, mode_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rx_bit;
  logic start_edge;
  logic par_en;
  logic par_expected;
  logic accept;

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;
  assign rx_bit = (rx_sync_q & rx_prev_q) | (rx_sync_q & rx_prev2_q) |
                  (rx_prev_q & rx_prev2_q);
`else
  assign rx_bit = rx_sync_q;
`endif

  assign start_edge   = rx_prev_q & ~rx_sync_q;
  assign par_en       = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign par_expected = (mode_q == 2'b10) ? ~^shift_q : ^shift_q;
  assign accept       = valid_q & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2_q  <= 1'b1;
`endif
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      mode_q      <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= i_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
`ifdef UART_RX_MAJORITY_EN
      rx_prev2_q  <= rx_prev_q;
`endif
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      mode_q      <= mode_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      done_q      <= done_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    mode_d      = mode_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d     = S_START;
          mode_d      = i_parity_mode;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == START_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_bit ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d       = '0;
          perr_pend_d = rx_bit ^ par_expected;
          state_d     = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (!rx_bit) ferr_pend_d = 1'b1;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            // A low final stop bit may be a break; hold off start detection
            // until the line is seen high again.
            state_d = rx_bit ? S_IDLE : S_WAIT_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake first, then a completing frame overrides it: a frame finishing
  // on the accepting edge reloads the holding register without overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (accept) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    if (done_q) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = perr_pend_q;
        ferr_d  = ferr_pend_q;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param. Runs the receiver at 16 clocks per
// bit (50 MHz / 3.125 MBd) and drives the serial line cycle by cycle so the
// mid-bit glitch lands on a known clock.

module tb_uart_rx_param;

  localparam int CPB      = 16;
  localparam int HALF_BIT = CPB / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h55;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h5D;
`endif

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic [1:0] i_parity_mode;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_overrun;

  int checks   = 0;
  int failures = 0;

  // Accepted words as {overrun, frame_err, parity_err, data}.
  logic [10:0] rxq[$];

  uart_rx_param #(
    .CLK_FREQ (50_000_000),
    .BAUD     (3_125_000),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .i_parity_mode(i_parity_mode),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  always begin
    @(negedge i_clk);
    #2;
    if (o_valid === 1'b1 && i_ready === 1'b1)
      rxq.push_back({o_overrun, o_frame_err, o_parity_err, o_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] data,
                              input logic perr, input logic ferr, input logic ovr);
    logic [10:0] e;
    chk({tag, "_count"}, rxq.size(), 1);
    if (rxq.size() != 0) e = rxq.pop_front();
    else                 e = 'x;
    chk({tag, "_data"}, e[7:0], data);
    chk({tag, "_perr"}, e[8], perr);
    chk({tag, "_ferr"}, e[9], ferr);
    chk({tag, "_ovr"},  e[10], ovr);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  // Called just after a negedge; line cycle c is driven before posedge c.
  // Leaves i_rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_bit,
                            input int glitch_at);
    logic bits[11];
    int   n;
    int   c;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    n = 9;
    if (par_en) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    c = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < CPB; k++) begin
        i_rx = (c == glitch_at) ? ~bits[b] : bits[b];
        @(negedge i_clk);
        c++;
      end
    end
  endtask

  logic [7:0] t1_words [4] = '{8'h28, 8'h73, 8'h55, 8'h43};
  logic       pre_bits [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    i_rst         = 1'b1;
    i_rx          = 1'b1;
    i_ready       = 1'b1;
    i_parity_mode = 2'b00;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_perr", o_parity_err, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_ovr", o_overrun, 0);
    i_rst = 1'b0;
    idle(4);

    // Plain 8N1 words.
    foreach (t1_words[i]) begin
      send_frame(t1_words[i], 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      expect_frame($sformatf("n81_%0h", t1_words[i]), t1_words[i], 1'b0, 1'b0, 1'b0);
    end

    // 0x73 has five ones: even parity bit 1; 0x55 has four: odd parity bit 1.
    i_parity_mode = 2'b01;
    send_frame(8'h73, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    expect_frame("even_ok", 8'h73, 1'b0, 1'b0, 1'b0);
    send_frame(8'h73, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    expect_frame("even_bad", 8'h73, 1'b1, 1'b0, 1'b0);
    i_parity_mode = 2'b10;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    expect_frame("odd_bad", 8'h55, 1'b1, 1'b0, 1'b0);
    i_parity_mode = 2'b00;

    // Low stop bit with the line held low for three bit times in total.
    send_frame(8'h43, 1'b0, 1'b0, 1'b0, -1);
    repeat (2 * CPB) @(negedge i_clk);
    expect_frame("ferr", 8'h43, 1'b0, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("ferr_no_spurious", rxq.size(), 0);
    chk("ferr_valid_low", o_valid, 0);
    send_frame(8'h28, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    expect_frame("after_ferr", 8'h28, 1'b0, 1'b0, 1'b0);

    // Overrun: second word dropped while the first is held.
    i_ready = 1'b0;
    send_frame(8'h28, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    chk("hold_valid", o_valid, 1);
    chk("hold_data", o_data, 8'h28);
    chk("hold_ovr", o_overrun, 0);
    send_frame(8'h73, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    chk("ovr_valid", o_valid, 1);
    chk("ovr_data", o_data, 8'h28);
    chk("ovr_flag", o_overrun, 1);
    chk("ovr_none_accepted", rxq.size(), 0);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    @(negedge i_clk);
    chk("ovr_clr_valid", o_valid, 0);
    chk("ovr_clr_flag", o_overrun, 0);
    expect_frame("ovr_word", 8'h28, 1'b0, 1'b0, 1'b1);
    i_ready = 1'b1;

    // 100 ns (5 clock) glitch on an idle line is a false start.
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    idle(12 * CPB);
    chk("glitch_none", rxq.size(), 0);
    chk("glitch_valid", o_valid, 0);

    // Reset part-way through 0x55: start bit plus data bits 0..3.
    foreach (pre_bits[b]) begin
      i_rx = pre_bits[b];
      repeat (CPB) @(negedge i_clk);
    end
    i_rst = 1'b1;
    i_rx  = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_data", o_data, 0);
    chk("midrst_valid", o_valid, 0);
    idle(12 * CPB);
    chk("midrst_none", rxq.size(), 0);
    send_frame(8'h43, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    expect_frame("after_rst", 8'h43, 1'b0, 1'b0, 1'b0);

    // One-cycle inversion at the centre of data bit 3.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, HALF_BIT + 4 * CPB);
    idle(4);
    expect_frame("midglitch", GLITCH_EXP, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
